// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch constants and the redirect-select encoding.
package mips_pkg;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {SEL_NONE, SEL_BRANCH, SEL_JUMP, SEL_JR} redirect_sel_e;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational redirect-target mux (jr > jump > branch) and sequential pc+4.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_if_id_pc4,
  input  logic          i_branch_taken,
  input  logic [15:0]   i_branch_offset,
  input  logic          i_jump,
  input  logic [25:0]   i_jump_index,
  input  logic          i_jr,
  input  logic [31:0]   i_jr_addr,
  output redirect_sel_e o_sel,
  output logic [31:0]   o_next_pc,
  output logic          o_misalign
);
  logic [31:0] w_target;
  always_comb begin
    o_sel = i_jr ? SEL_JR : i_jump ? SEL_JUMP : i_branch_taken ? SEL_BRANCH : SEL_NONE;
    w_target = o_sel == SEL_JR   ? i_jr_addr :
               o_sel == SEL_JUMP ? {i_if_id_pc4[31:28], i_jump_index, 2'b00} :
                                   i_if_id_pc4 + {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
    o_misalign = (o_sel != SEL_NONE) && (|w_target[1:0]);
    o_next_pc = (o_sel == SEL_NONE) ? i_pc + PC_INC : w_target & ~32'h3;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline register and sticky misalignment flag.
// FETCH_BRANCH_DELAY_SLOT_EN: redirects capture the delay-slot word instead of flushing.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misaligned_err
);
  logic [31:0] r_pc, r_instr, r_pc4;
  logic r_valid, r_err;
  mips_pkg::redirect_sel_e w_sel;
  logic [31:0] w_next_pc;
  logic w_misalign, w_redirect;
  next_pc_calc u_next_pc (
    .i_pc(r_pc),
    .i_if_id_pc4(r_pc4),
    .i_branch_taken(branch_taken),
    .i_branch_offset(branch_offset),
    .i_jump(jump),
    .i_jump_index(jump_index),
    .i_jr(jr),
    .i_jr_addr(jr_addr),
    .o_sel(w_sel),
    .o_next_pc(w_next_pc),
    .o_misalign(w_misalign)
  );
  assign w_redirect = w_sel != mips_pkg::SEL_NONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_instr <= NOP_WORD;
      r_pc4 <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= w_next_pc;
      r_err <= r_err | w_misalign;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
      r_instr <= imem_data;
      r_pc4 <= r_pc + mips_pkg::PC_INC;
      r_valid <= 1'b1;
`else
      r_instr <= NOP_WORD;
      r_pc4 <= '0;
      r_valid <= 1'b0;
`endif
    end else if (!stall) begin
      r_pc <= w_next_pc;
      r_instr <= imem_data;
      r_pc4 <= w_next_pc;
      r_valid <= 1'b1;
    end
  end
  assign imem_addr = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4 = r_pc4;
  assign if_id_valid = r_valid;
  assign misaligned_err = r_err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural fetch model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc4, jr_addr;
  logic stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [15:0] branch_offset = '0;
  logic [25:0] jump_index = '0;
  logic if_id_valid, misaligned_err;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic m_valid, m_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h100) return 32'h1111_1111;
    if (a == 32'h104) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = mem(imem_addr);

  fetch_unit #(.RESET_PC(RPC), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .misaligned_err(misaligned_err)
  );

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_offset = '0; jump_index = '0; jr_addr = '0;
  endtask

  // Model advances from the inputs present just before the edge, then outputs are sampled 1 ns after it.
  task automatic step();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
    end else if (jr || jump || branch_taken) begin
      if (jr) tgt = jr_addr;
      else if (jump) tgt = {m_pc4[31:28], jump_index, 2'b00};
      else tgt = m_pc4 + 32'($signed(branch_offset) * 4);
      if (tgt % 4 != 0) m_err = 1;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
      m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
`else
      m_instr = 0; m_pc4 = 0; m_valid = 0;
`endif
      m_pc = tgt - (tgt % 4);
    end else if (!stall) begin
      m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); step();
    vectors++;
    if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid, misaligned_err} !== {RPC, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got pc=%h instr=%h pc4=%h v=%b err=%b required pc=%h zeros", imem_addr, if_id_instr, if_id_pc4, if_id_valid, misaligned_err, RPC);
    end
  endtask

  task automatic test_stream();
    reset = 0; step();
    vectors++;
    if ({if_id_instr, if_id_pc4, if_id_valid} !== {32'h1111_1111, 32'h104, 1'b1}) begin
      miscompares++;
      $display("FAIL stream_first: got %h/%h/%b required 11111111/00000104/1", if_id_instr, if_id_pc4, if_id_valid);
    end
    step();
    vectors++;
    if ({if_id_instr, if_id_pc4, imem_addr} !== {32'h2222_2222, 32'h108, 32'h108}) begin
      miscompares++;
      $display("FAIL stream_second: got %h/%h pc=%h required 22222222/00000108 pc=00000108", if_id_instr, if_id_pc4, imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, in0, p40;
    step(); step();
    pc0 = imem_addr; in0 = if_id_instr; p40 = if_id_pc4;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {pc0, in0, p40, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got pc=%h instr=%h required pc=%h instr=%h", i, imem_addr, if_id_instr, pc0, in0);
      end
    end
    stall = 0; step();
    vectors++;
    if ({imem_addr, if_id_instr, if_id_pc4} !== {pc0 + 32'd4, mem(pc0), pc0 + 32'd4}) begin
      miscompares++;
      $display("FAIL stall_resume: got pc=%h instr=%h pc4=%h required pc=%h instr=%h", imem_addr, if_id_instr, if_id_pc4, pc0 + 32'd4, mem(pc0));
    end
  endtask

  task automatic test_branch();
    reset = 1; step(); reset = 0; step();
    branch_taken = 1; branch_offset = 16'hFFFF; step(); idle();
    vectors++;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
    if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h100, 32'h2222_2222, 32'h108, 1'b1}) begin
`else
    if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h100, 32'h0, 32'h0, 1'b0}) begin
`endif
      miscompares++;
      $display("FAIL branch_back: got pc=%h instr=%h pc4=%h v=%b model pc=%h instr=%h pc4=%h v=%b", imem_addr, if_id_instr, if_id_pc4, if_id_valid, m_pc, m_instr, m_pc4, m_valid);
    end
  endtask

  task automatic test_jr_priority();
    jr = 1; jump = 1; stall = 1; jr_addr = 32'h2000; jump_index = 26'h3FF_FFFF; step(); idle();
    vectors++;
    if (imem_addr !== 32'h2000 || misaligned_err !== 1'b0) begin
      miscompares++;
      $display("FAIL jr_priority: got pc=%h err=%b required pc=00002000 err=0", imem_addr, misaligned_err);
    end
  endtask

  task automatic test_misalign();
    jr = 1; jr_addr = 32'h2002; step(); idle();
    vectors++;
    if (imem_addr !== 32'h2000 || misaligned_err !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_set: got pc=%h err=%b required pc=00002000 err=1", imem_addr, misaligned_err);
    end
    step(); stall = 1; step(); idle(); jump = 1; jump_index = 26'h10; step(); idle();
    vectors++;
    if (misaligned_err !== 1'b1 || imem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL misalign_sticky: got err=%b pc=%h required err=1 pc=00000040", misaligned_err, imem_addr);
    end
    reset = 1; step(); reset = 0;
    vectors++;
    if (misaligned_err !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_clear: got err=%b required 0", misaligned_err);
    end
  endtask

  task automatic test_wrap();
    step(); jr = 1; jr_addr = 32'hFFFF_FFFC; step(); idle();
    vectors++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_jr: got pc=%h required fffffffc", imem_addr);
    end
    step();
    vectors++;
    if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== {32'h0, 32'h0, mem(32'hFFFF_FFFC), 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_inc: got pc=%h pc4=%h instr=%h required pc=0 pc4=0 instr=%h", imem_addr, if_id_pc4, if_id_instr, mem(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      jump = ($urandom_range(0, 11) == 0);
      jr = ($urandom_range(0, 11) == 0);
      branch_offset = 16'($urandom);
      jump_index = 26'($urandom);
      jr_addr = $urandom;
      step();
      vectors++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid, misaligned_err} !== {m_pc, m_instr, m_pc4, m_valid, m_err}) begin
        miscompares++;
        $display("FAIL random%0d: got pc=%h instr=%h pc4=%h v=%b err=%b required pc=%h instr=%h pc4=%h v=%b err=%b", i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, misaligned_err, m_pc, m_instr, m_pc4, m_valid, m_err);
      end
    end
    reset = 0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_jr_priority();
    test_misalign();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned 32-bit word into an IF/ID pipeline register for the decoder.
- Computes branch, jump and jump-register targets from decode-stage controls.
- Handles stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush/reset (MIPS sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory (= pc register, combinational)
- imem_data  in  32  instruction word returned combinationally for imem_addr
- stall  in  1  hold PC and IF/ID (hazard unit)
- branch_taken  in  1  conditional branch in ID resolved taken
- branch_offset  in  16  signed word offset from ID instruction [15:0]
- jump  in  1  J/JAL in ID
- jump_index  in  26  ID instruction [25:0]
- jr  in  1  JR/JALR in ID
- jr_addr  in  32  register value for JR
- if_id_instr  out  32  registered instruction for decode
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- misaligned_err  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset has priority over everything. On the edge with reset=1:
  - pc=RESET_PC
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0
  - misaligned_err=0
- Reset asserted mid-stall or mid-redirect discards that activity.
- redirect = jr | jump | branch_taken. Target priority is jr > jump > branch:
  - jr: jr_addr
  - jump: {if_id_pc4[31:28], jump_index, 2'b00}
  - branch: if_id_pc4 + (sign_extend(branch_offset) << 2)
  - All arithmetic is mod 2^32; wrap-around is silent.
- Misaligned target: pc loads target & ~32'h3 and misaligned_err sets. It stays set until reset.
- Per-edge priority (not reset): redirect > stall > normal.
- Normal edge:
  - pc <= pc+4 (0xFFFF_FFFC wraps to 0)
  - if_id_instr <= imem_data, if_id_pc4 <= pc+4, if_id_valid <= 1
- Stall edge (no redirect): pc and all IF/ID outputs hold their values.
- Redirect edge (with or without stall): pc <= target; IF/ID flushed to NOP_WORD with valid=0 and pc4=0.
- Latency: the word at address A appears on if_id_instr exactly one edge after pc==A is presented.
- The first valid instruction after reset appears on the first non-stalled edge after reset deasserts.
- imem_addr always equals pc; it carries no extra register.

Optional Feature:
- Macro: FETCH_BRANCH_DELAY_SLOT_EN.
- Defined: a redirect edge does not flush. IF/ID captures imem_data, pc+4 and valid=1 as on a normal edge (the delay-slot instruction), and pc <= target.
- Undefined: a redirect edge flushes IF/ID as described in Behaviour.

Decomposition:
- Shared package (mips_pkg):
  - NOP_WORD constant
  - PC_INC=4 constant
  - opcode-independent typedef for the redirect select (NONE/BRANCH/JUMP/JR)
- Sub-module: next_pc_calc. Purely combinational target mux and adders, producing next_pc and misalign.
- fetch_unit keeps the PC register, the IF/ID register and the sticky error.

Test Plan:
- Reset with RESET_PC=0x100, memory words 0x11111111@0x100, 0x22222222@0x104; release reset.
  -> imem_addr=0x100; next edge if_id_instr=0x11111111, if_id_pc4=0x104, valid=1; following edge 0x22222222.
- stall=1 for 3 edges mid-stream.
  -> pc and if_id_* unchanged for those 3 edges; stream resumes with no skipped or duplicated word.
- if_id_pc4=0x104, branch_taken=1, branch_offset=16'hFFFF.
  -> pc=0x100; IF/ID flushed (valid=0, instr=0).
  -> With FETCH_BRANCH_DELAY_SLOT_EN: IF/ID holds the slot word with valid=1.
- jr=1, jump=1, jr_addr=0x0000_2000, jump_index=0x3FFFFFF, same edge as stall=1.
  -> pc=0x2000 (jr wins, redirect beats stall).
- jr=1, jr_addr=0x0000_2002.
  -> pc=0x2000; misaligned_err=1, held until reset; reset clears it to 0.
- Start pc at 0xFFFF_FFFC via jr, no stall.
  -> next pc=0x0000_0000; if_id_pc4=0x0000_0000.
